// File: rtl/minmax_stream.sv
// Streaming window min/max/range unit: tracks running extremes over a start-opened
// window of len samples and presents max, min and max-min on a held valid/ready result.
module minmax_stream #(
  parameter int WIDTH  = 8,
  parameter int CNT_W  = 8,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] min,
  output logic [WIDTH:0]   diff,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [CNT_W-1:0]       r_rem;
  logic                   r_first;
  logic [WIDTH-1:0]       r_run_max_p0;
  logic [WIDTH-1:0]       r_run_min_p0;
  logic [WIDTH-1:0]       r_max_p1;
  logic [WIDTH-1:0]       r_min_p1;
  logic [WIDTH:0]         r_diff_p1;
  logic                   w_accept;
  logic                   w_last;
  logic                   w_open;
  logic [WIDTH-1:0]       w_cand_max;
  logic [WIDTH-1:0]       w_cand_min;
  logic signed [WIDTH:0]  w_diff;

  function automatic logic gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    else             return a > b;
  endfunction

  // Widening by one bit makes max-min exact in either mode; it can never go negative.
  function automatic logic signed [WIDTH:0] ext(input logic [WIDTH-1:0] a);
    if (SIGNED != 0) return $signed({a[WIDTH-1], a});
    else             return $signed({1'b0, a});
  endfunction

  always_comb begin
    w_open     = (r_state == S_IDLE) && start && (len != '0);
    w_accept   = (r_state == S_ACCUM) && in_valid;
    w_last     = w_accept && (r_rem == CNT_W'(1));
    w_cand_max = r_run_max_p0;
    w_cand_min = r_run_min_p0;
    if (r_first || gt(in_data, r_run_max_p0)) w_cand_max = in_data;
    if (r_first || gt(r_run_min_p0, in_data)) w_cand_min = in_data;
    w_diff     = ext(w_cand_max) - ext(w_cand_min);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_open)    w_next = S_ACCUM;
      S_ACCUM: if (w_last)    w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default:                w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rem        <= '0;
      r_first      <= 1'b0;
      r_run_max_p0 <= '0;
      r_run_min_p0 <= '0;
      r_max_p1     <= '0;
      r_min_p1     <= '0;
      r_diff_p1    <= '0;
    end else begin
      r_state <= w_next;
      if (w_open) begin
        r_rem   <= len;
        r_first <= 1'b1;
      end
      // p0: running extremes updated on every accepted sample
      if (w_accept) begin
        r_run_max_p0 <= w_cand_max;
        r_run_min_p0 <= w_cand_min;
        r_first      <= 1'b0;
        r_rem        <= r_rem - 1'b1;
      end
      // p1: result registers, written only when the window closes
      if (w_last) begin
        r_max_p1  <= w_cand_max;
        r_min_p1  <= w_cand_min;
        r_diff_p1 <= $unsigned(w_diff);
      end
    end
  end

  assign in_ready  = (r_state == S_ACCUM);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign max       = r_max_p1;
  assign min       = r_min_p1;
  assign diff      = r_diff_p1;

endmodule

// File: doc/minmax_stream.md
# minmax_stream

Streaming min/max/range unit with registered outputs. A `start` pulse opens a window of `len` samples. Samples are accepted over a valid/ready handshake, one per cycle at most. The block tracks the running maximum and minimum in signed or unsigned mode, then presents max, min and their difference as a held result on an output valid/ready handshake. It sits between a sample source and downstream statistics or display logic.

## Interface
- `WIDTH`, 8: sample width in bits.
- `CNT_W`, 8: width of the window-length field; maximum window is 2^CNT_W−1 samples.
- `SIGNED`, 0: 0 = unsigned compare, 1 = two's-complement compare.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `start`  in  1  opens a window; sampled only in IDLE.
- `len`  in  CNT_W  number of samples in the window; sampled with `start`.
- `in_valid`  in  1  `in_data` is valid.
- `in_data`  in  WIDTH  sample.
- `in_ready`  out  1  block accepts a sample this cycle.
- `out_valid`  out  1  result is valid.
- `out_ready`  in  1  consumer takes the result.
- `max`  out  WIDTH  window maximum.
- `min`  out  WIDTH  window minimum.
- `diff`  out  WIDTH+1  max − min, unsigned magnitude.
- `busy`  out  1  state is not IDLE.

## Operation
- FSM has three states: IDLE, ACCUM and DONE.
- **IDLE**
  - `in_ready`=0 and `out_valid`=0.
  - `start`=1 with `len`≠0: latch `len` into the remaining counter, set the first-sample flag, go to ACCUM.
  - `start` with `len`=0: ignored; stay in IDLE.
- **ACCUM**
  - `in_ready`=1 (combinational from state).
  - A sample is accepted when `in_valid`&&`in_ready`.
  - First accepted sample: load running max and running min with it; clear the first-sample flag.
  - Later samples: running max ← sample if sample > running max; running min ← sample if sample < running min.
  - Ties leave the running values unchanged.
  - Compares use `$signed` when SIGNED=1 and unsigned otherwise.
  - Each accept decrements the remaining counter.
  - Accept while remaining==1: write the final max/min (including this sample) into the result registers, compute `diff`, go to DONE.
  - Cycles with `in_valid`=0 change nothing.
- **DONE**
  - `out_valid`=1; `max`/`min`/`diff` stable.
  - On `out_valid`&&`out_ready`: go to IDLE.
- `start` is ignored in ACCUM and DONE.
- Result registers hold their last value after the handshake, until the next window completes.
- **diff arithmetic**
  - Extend max and min to WIDTH+1 bits: sign-extend if SIGNED=1, zero-extend otherwise.
  - Subtract; the result is always ≥0 and never overflows.
- **Reset**
  - State IDLE; `max`, `min`, `diff`, running registers and counter = 0; `out_valid`=0, `in_ready`=0, `busy`=0.
  - Reset asserted mid-ACCUM or mid-DONE aborts the window. The partial result is discarded and never presented.

## Timing
- `start` sampled at edge E0 → ACCUM from cycle E0+1; the first sample can be accepted at edge E0+1.
- Last sample accepted at edge Ek → `out_valid`=1 and outputs valid in cycle Ek+1.
- Latency from last accept to result: 1 cycle.
- Throughput: one sample per cycle with `in_valid` held high.
- Window of N samples with no stalls:
  - N+1 edges from `start` to `out_valid`.
  - Minimum 1 further cycle in DONE before a new `start` can be accepted.
- Back-pressure: `out_ready`=0 holds DONE indefinitely; outputs and `out_valid` stay stable; no samples accepted (`in_ready`=0).
- `out_ready`=1 on the first DONE cycle → IDLE next cycle, so `out_valid` is high for exactly 1 cycle.
- `out_ready` is ignored outside DONE.

## Test plan
- Unsigned, WIDTH=8, `len`=3, samples 5, 200, 17 → `max`=200, `min`=5, `diff`=195. `out_valid` rises one cycle after the third accept.
- SIGNED=1, WIDTH=8, `len`=2, samples 8'h80 (−128), 8'h7F (127) → `max`=8'h7F, `min`=8'h80, `diff`=9'd255. Same stimulus with SIGNED=0 → `max`=8'h80, `min`=8'h7F, `diff`=1.
- `len`=1, sample 42 → `max`=`min`=42, `diff`=0. `len`=0 with `start` → stays IDLE, `busy`=0, no `out_valid`.
- `len`=4, `in_valid` toggled 1,0,0,1,1,0,1 with values 9,x,x,3,9,x,3 → only the 4 valid beats count; `max`=9, `min`=3, `diff`=6. Then hold `out_ready`=0 for 5 cycles → `out_valid`, outputs, `in_ready`=0 stable. A `start` pulse in DONE is ignored. Raise `out_ready` → IDLE next cycle.
- Start `len`=5, accept 2 samples, assert `rst` 1 cycle → next cycle IDLE with all outputs 0. A new `len`=2 window with 7, 7 → `max`=`min`=7, `diff`=0, with no trace of pre-reset samples.
- Back-to-back windows: 3, 1, 2 then 10, 20 → first result `max`=3, `min`=1, `diff`=2. Second result `max`=20, `min`=10, `diff`=10; between them, result registers hold the first result.
